// File: rtl/fft_sequencer_pkg.sv
// Shared definitions for the FFT phase sequencer: AGU modes, phase encodings, run lengths.
// The TWID phase encoding exists only when FFT_SEQ_TWIDDLE_LOAD_EN is defined.
package fft_sequencer_pkg;

  localparam int AGU_MODE_WIDTH = 2;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_OP_RAM  = 2'd0;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_ROM_RAM = 2'd1;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_BF_RAM  = 2'd2;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_RAM_OP  = 2'd3;

  localparam int FFT_SEQ_PHASE_WIDTH = 3;

  typedef enum logic [FFT_SEQ_PHASE_WIDTH-1:0] {
    PH_IDLE   = 3'd0,
    PH_LOAD   = 3'd1,
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
    PH_TWID   = 3'd2,
`endif
    PH_BF     = 3'd3,
    PH_UNLOAD = 3'd4,
    PH_FIN    = 3'd5
  } fft_seq_phase_e;

  typedef enum logic [1:0] {SS_RST, SS_GO, SS_RUN} fft_seq_step_e;

  function automatic int load_run_len(input int n);
    return n;
  endfunction

  function automatic int twid_run_len(input int rom_words);
    return rom_words;
  endfunction

  // Eight cycles per butterfly slot, N/2 butterflies per stage, plus write-back drain.
  function automatic int bf_run_len(input int n, input int log_n, input int drain);
    return log_n * (n / 2) * 8 + drain;
  endfunction

  // One extra cycle covers the RAM read latency of the final word.
  function automatic int unload_run_len(input int n);
    return n + 1;
  endfunction

  function automatic int bf_stage_shift(input int n);
    return $clog2((n / 2) * 8);
  endfunction

endpackage

// File: rtl/fft_sequencer_phase_counter.sv
// Phase cycle counter: clear loads a new terminal limit, enable counts up, tc flags the limit.
module fft_seq_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] lim_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      lim_q <= '0;
    end else if (clr) begin
      count <= '0;
      lim_q <= limit;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = en && (count == lim_q);

endmodule

// File: rtl/fft_sequencer.sv
// Phase controller for the radix-2 FFT core: LOAD, (TWID), BF, UNLOAD, each as RST/GO/RUN.
// Define FFT_SEQ_TWIDDLE_LOAD_EN to include the ROM->RAM twiddle copy phase.
module fft_sequencer
  import fft_sequencer_pkg::*;
#(
  parameter int NO_OF_POINTS = 128,
  parameter int LOG_N        = 7,
  parameter int ROM_WORDS    = 128,
  parameter int BF_DRAIN     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      ifft,
  input  logic                      x_we_ram,
  output logic                      agu_reset,
  output logic                      agu_start,
  output logic [AGU_MODE_WIDTH-1:0] agu_mode,
  output logic                      agu_ifft,
  output logic                      agu_oe,
  output logic                      ram_we,
  output logic                      out_valid,
  output logic [2:0]                stage,
  output logic                      busy,
  output logic                      done
);

  localparam int LOAD_RUN   = load_run_len(NO_OF_POINTS);
  localparam int TWID_RUN   = twid_run_len(ROM_WORDS);
  localparam int BF_RUN     = bf_run_len(NO_OF_POINTS, LOG_N, BF_DRAIN);
  localparam int UNLOAD_RUN = unload_run_len(NO_OF_POINTS);
  localparam int STG_SHIFT  = bf_stage_shift(NO_OF_POINTS);
  localparam logic [CNT_W-1:0] STG_MAX = CNT_W'(LOG_N - 1);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(NO_OF_POINTS);
  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  // The counter must reach RUN-1 of every phase without wrapping.
  if (longint'(LOAD_RUN) > CNT_SPAN || longint'(TWID_RUN) > CNT_SPAN ||
      longint'(BF_RUN) > CNT_SPAN || longint'(UNLOAD_RUN) > CNT_SPAN) begin : g_cnt_w_check
    $error("fft_sequencer: CNT_W=%0d too narrow for BF run of %0d cycles", CNT_W, BF_RUN);
  end

  fft_seq_phase_e   ph, nxt_ph;
  fft_seq_step_e    ss, nxt_ss;
  logic [CNT_W-1:0] cnt, nxt_cnt, lim, slot;
  logic             tc;

  function automatic fft_seq_phase_e phase_after(input fft_seq_phase_e p);
    case (p)
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
      PH_LOAD:   return PH_TWID;
      PH_TWID:   return PH_BF;
`else
      PH_LOAD:   return PH_BF;
`endif
      PH_BF:     return PH_UNLOAD;
      PH_UNLOAD: return PH_FIN;
      default:   return PH_IDLE;
    endcase
  endfunction

  function automatic logic [AGU_MODE_WIDTH-1:0] mode_of(input fft_seq_phase_e p);
    case (p)
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
      PH_TWID: return AGU_MODE_ROM_RAM;
`endif
      PH_BF:     return AGU_MODE_BF_RAM;
      PH_UNLOAD: return AGU_MODE_RAM_OP;
      default:   return AGU_MODE_OP_RAM;
    endcase
  endfunction

  fft_seq_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ss == SS_RST),
    .en    (ss == SS_RUN),
    .limit (lim),
    .count (cnt),
    .tc    (tc)
  );

  always_comb begin
    case (ph)
      PH_LOAD:   lim = CNT_W'(LOAD_RUN - 1);
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
      PH_TWID:   lim = CNT_W'(TWID_RUN - 1);
`endif
      PH_BF:     lim = CNT_W'(BF_RUN - 1);
      PH_UNLOAD: lim = CNT_W'(UNLOAD_RUN - 1);
      default:   lim = '0;
    endcase
  end

  // IDLE and FIN sit in SS_RST so the counter stays cleared between transforms.
  always_comb begin
    nxt_ph = ph;
    nxt_ss = ss;
    case (ph)
      PH_IDLE: if (start) begin
        nxt_ph = PH_LOAD;
        nxt_ss = SS_RST;
      end
      PH_FIN:  nxt_ph = PH_IDLE;
      default: begin
        case (ss)
          SS_RST:  nxt_ss = SS_GO;
          SS_GO:   nxt_ss = SS_RUN;
          default: if (tc) begin
            nxt_ph = phase_after(ph);
            nxt_ss = SS_RST;
          end
        endcase
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the count the next cycle will carry.
  assign nxt_cnt = (ss == SS_RUN) ? cnt + CNT_W'(1) : '0;
  assign slot    = nxt_cnt >> STG_SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      ph        <= PH_IDLE;
      ss        <= SS_RST;
      agu_reset <= 1'b1;
      agu_start <= 1'b0;
      agu_mode  <= AGU_MODE_OP_RAM;
      agu_ifft  <= 1'b0;
      agu_oe    <= 1'b0;
      ram_we    <= 1'b0;
      out_valid <= 1'b0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ph        <= nxt_ph;
      ss        <= nxt_ss;
      agu_reset <= (nxt_ss == SS_RST);
      agu_start <= (nxt_ss == SS_GO);
      if (nxt_ss == SS_RST && nxt_ph != PH_IDLE && nxt_ph != PH_FIN)
        agu_mode <= mode_of(nxt_ph);
      if (ph == PH_IDLE && start)
        agu_ifft <= ifft;
      agu_oe    <= (nxt_ph == PH_LOAD) || (nxt_ph == PH_BF)
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
                   || (nxt_ph == PH_TWID)
`endif
                   ;
      ram_we    <= 1'b0;
      out_valid <= 1'b0;
      stage     <= '0;
      if (nxt_ss == SS_RUN) begin
        case (nxt_ph)
          PH_LOAD:   ram_we <= 1'b1;
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
          PH_TWID:   ram_we <= 1'b1;
`endif
          PH_BF: begin
            ram_we <= x_we_ram;
            stage  <= (slot > STG_MAX) ? STG_MAX[2:0] : slot[2:0];
          end
          PH_UNLOAD: out_valid <= (nxt_cnt != '0) && (nxt_cnt <= N_CNT);
          default: ;
        endcase
      end
      busy      <= (nxt_ph != PH_IDLE);
      done      <= (nxt_ph == PH_FIN);
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer against a cycle-position model of the phase schedule.
`timescale 1ns/1ps
module tb_fft_sequencer;
  import fft_sequencer_pkg::*;

  localparam int N    = 128;
  localparam int SLOT = 512;
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
  localparam int DONE_T = 3982;
  localparam int NPH    = 4;
  localparam int BF_T0  = 263;
`else
  localparam int DONE_T = 3852;
  localparam int NPH    = 3;
  localparam int BF_T0  = 133;
`endif

  typedef struct packed {
    logic                      rst;
    logic                      st;
    logic [AGU_MODE_WIDTH-1:0] mode;
    logic                      ifft;
    logic                      oe;
    logic                      we;
    logic                      ov;
    logic [2:0]                stg;
    logic                      busy;
    logic                      done;
  } obs_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ifft = 1'b0, x_we_ram = 1'b0;
  logic agu_reset, agu_start, agu_ifft, agu_oe, ram_we, out_valid, busy, done;
  logic [AGU_MODE_WIDTH-1:0] agu_mode;
  logic [2:0] stage;
  obs_t got;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fft_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ifft(ifft), .x_we_ram(x_we_ram),
    .agu_reset(agu_reset), .agu_start(agu_start), .agu_mode(agu_mode),
    .agu_ifft(agu_ifft), .agu_oe(agu_oe), .ram_we(ram_we), .out_valid(out_valid),
    .stage(stage), .busy(busy), .done(done)
  );

  assign got = {agu_reset, agu_start, agu_mode, agu_ifft, agu_oe, ram_we, out_valid,
                stage, busy, done};

  function automatic obs_t rst_vec();
    obs_t o = '0;
    o.rst  = 1'b1;
    o.mode = AGU_MODE_OP_RAM;
    return o;
  endfunction

  // Expected outputs t cycles after the accepted start; px is x_we_ram of cycle t-1.
  function automatic obs_t model(input int t, input bit px, input bit fi);
    obs_t o = '0;
    int run[4];
    int kind[4];
    int r, p, rc;
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
    run  = '{128, 128, 3588, 129};
    kind = '{0, 1, 2, 3};
`else
    run  = '{128, 3588, 129, 0};
    kind = '{0, 2, 3, 0};
`endif
    o.ifft = fi;
    o.rst  = 1'b1;
    o.mode = AGU_MODE_RAM_OP;
    r = t - 1;
    p = -1;
    for (int i = 0; i < NPH; i++)
      if (p < 0) begin
        if (r < run[i] + 2) p = i;
        else r -= run[i] + 2;
      end
    if (p >= 0) begin
      o.busy = 1'b1;
      o.rst  = (r == 0);
      o.st   = (r == 1);
      o.oe   = (kind[p] != 3);
      case (kind[p])
        0: o.mode = AGU_MODE_OP_RAM;
        1: o.mode = AGU_MODE_ROM_RAM;
        2: o.mode = AGU_MODE_BF_RAM;
        default: o.mode = AGU_MODE_RAM_OP;
      endcase
      if (r >= 2) begin
        rc = r - 2;
        case (kind[p])
          0, 1: o.we = 1'b1;
          2: begin
            o.we  = px;
            o.stg = 3'((rc / SLOT > 6) ? 6 : rc / SLOT);
          end
          default: o.ov = (rc >= 1 && rc <= N);
        endcase
      end
    end else if (r == 0) begin
      o.busy = 1'b1;
      o.done = 1'b1;
    end
    return o;
  endfunction

  task automatic test_reset();
    obs_t rv = rst_vec();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x_we_ram = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (got !== rv) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, got, rv);
      end
    end
  endtask

  // Full transform with random x_we_ram and ignored starts during busy and on done.
  task automatic test_transform(input bit fi);
    obs_t e;
    bit xw;
    int done_at = -1, ov_cnt = 0, go_n = 0;
    int go_at[4] = '{-1, -1, -1, -1};
    int exp_go[4];
`ifdef FFT_SEQ_TWIDDLE_LOAD_EN
    exp_go = '{2, 132, 262, 3852};
`else
    exp_go = '{2, 132, 3722, 0};
`endif
    start = 1'b1;
    ifft  = fi;
    xw = 1'($urandom);
    x_we_ram = xw;
    for (int t = 1; t <= DONE_T + 3; t++) begin
      @(negedge clk);
      e = model(t, xw, fi);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL transform ifft=%0d t=%0d got=%h want=%h", fi, t, got, e);
      end
      if (t == BF_T0 + 3586) begin
        n_cmp++;
        if (stage !== 3'd6) begin
          n_bad++;
          $display("FAIL drain_stage got=%0d want=6", stage);
        end
      end
      if (got.done) done_at = t;
      if (got.ov) ov_cnt++;
      if (got.st) begin
        if (go_n < 4) go_at[go_n] = t;
        go_n++;
      end
      start = (t == DONE_T) || (t < DONE_T && $urandom_range(0, 63) == 0);
      ifft  = 1'($urandom);
      xw = 1'($urandom);
      x_we_ram = xw;
    end
    start = 1'b0;
    n_cmp++;
    if (done_at != DONE_T) begin
      n_bad++;
      $display("FAIL done_cycle got=%0d want=%0d", done_at, DONE_T);
    end
    n_cmp++;
    if (ov_cnt != N) begin
      n_bad++;
      $display("FAIL out_valid_count got=%0d want=%0d", ov_cnt, N);
    end
    n_cmp++;
    if (go_n != NPH) begin
      n_bad++;
      $display("FAIL agu_start_count got=%0d want=%0d", go_n, NPH);
    end
    for (int i = 0; i < NPH; i++) begin
      n_cmp++;
      if (go_at[i] != exp_go[i]) begin
        n_bad++;
        $display("FAIL agu_start_cycle idx=%0d got=%0d want=%0d", i, go_at[i], exp_go[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    obs_t rv = rst_vec();
    bit xw;
    start = 1'b1;
    ifft  = 1'b1;
    xw = 1'($urandom);
    x_we_ram = xw;
    for (int t = 1; t <= BF_T0 + 1000; t++) begin
      @(negedge clk);
      e = model(t, xw, 1'b1);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL pre_abort t=%0d got=%h want=%h", t, got, e);
      end
      start = ($urandom_range(0, 31) == 0);
      xw = 1'($urandom);
      x_we_ram = xw;
    end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (got !== rv) begin
        n_bad++;
        $display("FAIL mid_reset cyc=%0d got=%h want=%h", i, got, rv);
      end
      x_we_ram = 1'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_transform(1'b1);
    test_transform(1'b0);
    test_reset_mid();
    test_transform(1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
